// File: rtl/soc_test_monitor.sv
// SoC self-test monitor: snoops core data-port writes for per-channel completion flags and results.
// Optional result-vs-golden checking is compiled in when TEST_MON_CHECK_EN is defined.
module soc_test_monitor #(
    parameter int          NUM_CH      = 2,
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          FLAG_ADDR   = 0,
    parameter int          RESULT_ADDR = 1,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    input  logic [NUM_CH*DATA_W-1:0] expected_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic                     pass_o,
    output logic [NUM_CH-1:0]        done_mask_o,
    output logic [NUM_CH*DATA_W-1:0] result_o,
    output logic [31:0]              cycles_o
);

    localparam logic [ADDR_W-1:0] FLAG_A   = ADDR_W'(FLAG_ADDR);
    localparam logic [ADDR_W-1:0] RESULT_A = ADDR_W'(RESULT_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [NUM_CH-1:0]        r_done_mask;
    logic [NUM_CH*DATA_W-1:0] r_result;
    logic [31:0]              r_cycles;
    logic                     r_busy, r_done, r_timeout, r_pass;
    logic                     w_busy, w_done, w_timeout, w_pass;
    logic [NUM_CH-1:0]        w_flag_set;
    logic [NUM_CH-1:0]        w_res_wr;
    logic [NUM_CH-1:0]        w_mask_next;
    logic [31:0]              w_cycles_inc;
    logic                     w_all_done_r;
    logic                     w_all_done_next;
    logic                     w_tmo_hit;

    // Snoop decode; result capture stops once the channel has raised its flag
    always_comb begin
        w_flag_set = '0;
        w_res_wr   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_state == S_RUN && req_i[c] && we_i[c]) begin
                w_flag_set[c] = (addr_i[c*ADDR_W +: ADDR_W] == FLAG_A) &&
                                (wdata_i[c*DATA_W +: DATA_W] != '0);
                w_res_wr[c]   = (addr_i[c*ADDR_W +: ADDR_W] == RESULT_A) && !r_done_mask[c];
            end
        end
    end

    assign w_mask_next     = r_done_mask | w_flag_set;
    assign w_all_done_r    = &r_done_mask;
    assign w_all_done_next = &w_mask_next;
    assign w_cycles_inc    = (r_cycles == 32'hFFFF_FFFF) ? r_cycles : r_cycles + 32'd1;
    assign w_tmo_hit       = (w_cycles_inc == TIMEOUT_CYC);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_timeout <= w_timeout;
            r_pass    <= w_pass;
        end
    end

    // A flag completing the mask on the timeout cycle keeps RUN so DONE follows next
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_state_next = S_RUN;
            S_RUN: begin
                if (w_all_done_r)
                    w_state_next = S_DONE;
                else if (w_tmo_hit && !w_all_done_next)
                    w_state_next = S_TIMEOUT;
            end
            S_DONE,
            S_TIMEOUT: if (!start_i) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

`ifdef TEST_MON_CHECK_EN
    logic w_match;

    always_comb begin
        w_match = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_result[c*DATA_W +: DATA_W] != expected_i[c*DATA_W +: DATA_W])
                w_match = 1'b0;
        end
    end
`else
    logic w_unused_expected;
    assign w_unused_expected = ^expected_i;
`endif

    always_comb begin
        w_busy    = (w_state_next == S_RUN);
        w_done    = (w_state_next == S_DONE);
        w_timeout = (w_state_next == S_TIMEOUT);
`ifdef TEST_MON_CHECK_EN
        w_pass    = w_done && w_match;
`else
        w_pass    = w_done;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_done_mask <= '0;
            r_result    <= '0;
            r_cycles    <= '0;
        end else if (r_state == S_IDLE && start_i) begin
            r_done_mask <= '0;
            r_result    <= '0;
            r_cycles    <= '0;
        end else if (r_state == S_RUN) begin
            r_cycles    <= w_cycles_inc;
            r_done_mask <= w_mask_next;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_res_wr[c])
                    r_result[c*DATA_W +: DATA_W] <= wdata_i[c*DATA_W +: DATA_W];
            end
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign timeout_o   = r_timeout;
    assign pass_o      = r_pass;
    assign done_mask_o = r_done_mask;
    assign result_o    = r_result;
    assign cycles_o    = r_cycles;

endmodule

// File: tb/tb_soc_test_monitor.sv
// Bench for soc_test_monitor: directed vector table, corner-case sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_soc_test_monitor;

    localparam int          NUM_CH = 2;
    localparam int          DW     = 32;
    localparam int          AW     = 32;
    localparam logic [31:0] TMO    = 32'd100;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_TMO = 3;

    logic                 clk = 1'b0;
    logic                 rst, start;
    logic [NUM_CH-1:0]    req, we;
    logic [NUM_CH*AW-1:0] addr;
    logic [NUM_CH*DW-1:0] wdata, expected;
    logic                 busy, done, tmo, pass;
    logic [NUM_CH-1:0]    mask;
    logic [NUM_CH*DW-1:0] result;
    logic [31:0]          cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    soc_test_monitor #(
        .NUM_CH(NUM_CH), .DATA_W(DW), .ADDR_W(AW),
        .FLAG_ADDR(0), .RESULT_ADDR(1), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .req_i(req), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .expected_i(expected),
        .busy_o(busy), .done_o(done), .timeout_o(tmo), .pass_o(pass),
        .done_mask_o(mask), .result_o(result), .cycles_o(cycles)
    );

    typedef struct {
        logic        r, s;
        logic [1:0]  rq, w;
        logic [31:0] a0, a1, d0, d1;
        logic        e_busy, e_done, e_tmo, e_pass;
        logic [1:0]  e_mask;
        logic [31:0] e_r0, e_r1, e_cyc;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic s, input logic [1:0] rq, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        rst = r; start = s; req = rq; we = w;
        addr = {a1, a0}; wdata = {d1, d0};
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] rq, input logic [1:0] w,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic eb, input logic ed, input logic et, input logic ep,
                                input logic [1:0] em, input logic [31:0] r0, input logic [31:0] r1,
                                input logic [31:0] ec);
        vec_t v;
        v.r = r; v.s = s; v.rq = rq; v.w = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.e_busy = eb; v.e_done = ed; v.e_tmo = et; v.e_pass = ep;
        v.e_mask = em; v.e_r0 = r0; v.e_r1 = r1; v.e_cyc = ec;
        return v;
    endfunction

    // Behavioural model: state of the test run as the spec describes it
    int          m_mode;
    logic [1:0]  m_mask;
    logic [31:0] m_res[2];
    logic [31:0] m_cyc;
    logic        m_pass;

    task automatic model_step();
        logic       full_before;
        logic [1:0] new_mask;
        logic [31:0] a, d;
        if (rst) begin
            m_mode = M_IDLE; m_mask = 0; m_res[0] = 0; m_res[1] = 0; m_cyc = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode = M_RUN; m_mask = 0; m_res[0] = 0; m_res[1] = 0; m_cyc = 0;
                end
                M_RUN: begin
                    full_before = (m_mask == 2'b11);
                    new_mask = m_mask;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (req[c] && we[c]) begin
                            a = addr[c*AW +: AW];
                            d = wdata[c*DW +: DW];
                            if (a == 1 && !m_mask[c]) m_res[c] = d;
                            if (a == 0 && d != 0) new_mask[c] = 1'b1;
                        end
                    end
                    if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
                    m_mask = new_mask;
                    if (full_before) m_mode = M_DONE;
                    else if (m_cyc == TMO && new_mask != 2'b11) m_mode = M_TMO;
                end
                default: if (!start) m_mode = M_IDLE;
            endcase
        end
`ifdef TEST_MON_CHECK_EN
        m_pass = (m_mode == M_DONE) && ({m_res[1], m_res[0]} == expected);
`else
        m_pass = (m_mode == M_DONE);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic [31:0] prev;
        logic        exp_pass;
        int   sparse, x;
        logic [1:0] rq, w;
        logic [31:0] a[2], d[2];

        expected = {32'd66, 32'd77};
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        //         r s  rq    w     a0 a1 d0  d1  | bsy dn tmo ps mask r0  r1  cyc
        tbl[0]  = mk(1,0,2'b00,2'b00,0, 0, 0,  0,   0, 0, 0, 0, 2'b00, 0,  0,  0);
        tbl[1]  = mk(0,1,2'b00,2'b00,0, 0, 0,  0,   1, 0, 0, 0, 2'b00, 0,  0,  0);
        tbl[2]  = mk(0,1,2'b01,2'b01,1, 0, 55, 0,   1, 0, 0, 0, 2'b00, 55, 0,  1);
        tbl[3]  = mk(0,1,2'b11,2'b11,1, 1, 77, 66,  1, 0, 0, 0, 2'b00, 77, 66, 2);
        tbl[4]  = mk(0,1,2'b11,2'b01,0, 1, 0,  99,  1, 0, 0, 0, 2'b00, 77, 66, 3);
        tbl[5]  = mk(0,1,2'b01,2'b01,0, 0, 1,  0,   1, 0, 0, 0, 2'b01, 77, 66, 4);
        tbl[6]  = mk(0,1,2'b01,2'b01,1, 0, 5,  0,   1, 0, 0, 0, 2'b01, 77, 66, 5);
        tbl[7]  = mk(0,1,2'b10,2'b10,0, 0, 0,  7,   1, 0, 0, 0, 2'b11, 77, 66, 6);
        tbl[8]  = mk(0,1,2'b00,2'b00,0, 0, 0,  0,   0, 1, 0, 1, 2'b11, 77, 66, 7);
        tbl[9]  = mk(0,1,2'b01,2'b01,1, 0, 9,  0,   0, 1, 0, 1, 2'b11, 77, 66, 7);
        tbl[10] = mk(0,0,2'b00,2'b00,0, 0, 0,  0,   0, 0, 0, 0, 2'b11, 77, 66, 7);
        tbl[11] = mk(0,0,2'b10,2'b10,0, 1, 0,  3,   0, 0, 0, 0, 2'b11, 77, 66, 7);
        tbl[12] = mk(0,1,2'b00,2'b00,0, 0, 0,  0,   1, 0, 0, 0, 2'b00, 0,  0,  0);
        tbl[13] = mk(0,1,2'b01,2'b01,1, 0, 8,  0,   1, 0, 0, 0, 2'b00, 8,  0,  1);
        tbl[14] = mk(1,1,2'b01,2'b01,1, 0, 8,  0,   0, 0, 0, 0, 2'b00, 0,  0,  0);
        tbl[15] = mk(0,0,2'b01,2'b01,1, 0, 8,  0,   0, 0, 0, 0, 2'b00, 0,  0,  0);

        for (int i = 0; i < 16; i++) begin
            drv(tbl[i].r, tbl[i].s, tbl[i].rq, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d.done", i), done, tbl[i].e_done);
            chk($sformatf("vec%0d.timeout", i), tmo, tbl[i].e_tmo);
            chk($sformatf("vec%0d.pass", i), pass, tbl[i].e_pass);
            chk($sformatf("vec%0d.mask", i), mask, tbl[i].e_mask);
            chk($sformatf("vec%0d.res0", i), result[31:0], tbl[i].e_r0);
            chk($sformatf("vec%0d.res1", i), result[63:32], tbl[i].e_r1);
            chk($sformatf("vec%0d.cycles", i), cycles, tbl[i].e_cyc);
        end

        // Timeout with no flag writes
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        prev = cycles; n = 0;
        while (!tmo && n < 300) begin
            prev = cycles;
            @(negedge clk);
            n++;
        end
        chk("tmo.reached", tmo, 1);
        chk("tmo.cycles", cycles, 100);
        chk("tmo.prev_cycles", prev, 99);
        chk("tmo.done", done, 0);
        chk("tmo.pass", pass, 0);
        chk("tmo.busy", busy, 0);
        @(negedge clk);
        chk("tmo.hold", tmo, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("tmo.idle", tmo, 0);
        chk("tmo.idle_cycles_hold", cycles, 100);

        // Final flag lands on the timeout cycle: DONE wins
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drv(0, 1, 2'b01, 2'b01, 0, 0, 1, 0);
        @(negedge clk);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (cycles != 99 && n < 300) begin @(negedge clk); n++; end
        chk("tie.wait99", cycles, 99);
        drv(0, 1, 2'b10, 2'b10, 0, 0, 0, 2);
        @(negedge clk);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        chk("tie.cycles", cycles, 100);
        chk("tie.mask", mask, 2'b11);
        chk("tie.no_timeout", tmo, 0);
        @(negedge clk);
        chk("tie.done", done, 1);
        chk("tie.timeout_low", tmo, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Flags at cycle 10 and 30
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n = 0;
        while (cycles != 10 && n < 100) begin @(negedge clk); n++; end
        chk("flags.wait10", cycles, 10);
        drv(0, 1, 2'b01, 2'b01, 0, 0, 3, 0);
        @(negedge clk);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        chk("flags.mask01", mask, 2'b01);
        n = 0;
        while (cycles != 30 && n < 100) begin @(negedge clk); n++; end
        chk("flags.mask01_hold", mask, 2'b01);
        drv(0, 1, 2'b10, 2'b10, 0, 0, 0, 4);
        @(negedge clk);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        chk("flags.mask11", mask, 2'b11);
        chk("flags.not_done_yet", done, 0);
        @(negedge clk);
        chk("flags.done", done, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Result mismatch against golden
        expected = {32'd21, 32'd34};
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drv(0, 1, 2'b11, 2'b11, 1, 1, 21, 21);
        @(negedge clk);
        drv(0, 1, 2'b11, 2'b11, 0, 0, 1, 1);
        @(negedge clk);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        chk("golden.mask", mask, 2'b11);
        @(negedge clk);
`ifdef TEST_MON_CHECK_EN
        exp_pass = 1'b0;
`else
        exp_pass = 1'b1;
`endif
        chk("golden.done", done, 1);
        chk("golden.res", result, {32'd21, 32'd21});
        chk("golden.pass_mismatch", pass, exp_pass);
        expected = {32'd21, 32'd21};
        @(negedge clk);
        chk("golden.pass_match", pass, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("golden.idle_pass", pass, 0);

        // Randomized traffic against the model
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        model_step();
        @(negedge clk);
        for (int i = 0; i < 4000; i++) begin
            chk("rnd.busy", busy, m_mode == M_RUN);
            chk("rnd.done", done, m_mode == M_DONE);
            chk("rnd.timeout", tmo, m_mode == M_TMO);
            chk("rnd.pass", pass, m_pass);
            chk("rnd.mask", mask, m_mask);
            chk("rnd.result", result, {m_res[1], m_res[0]});
            chk("rnd.cycles", cycles, m_cyc);
            sparse = (i / 400) % 2;
            for (int c = 0; c < NUM_CH; c++) begin
                rq[c] = ($urandom_range(0, 3) == 0);
                w[c]  = ($urandom_range(0, 3) != 0);
                x = $urandom_range(0, 99);
                a[c] = (x < (sparse ? 2 : 10)) ? 32'd0 : (x < 60 ? 32'd1 : 32'($urandom_range(2, 5)));
                d[c] = 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 49) == 0)
                expected = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
            drv($urandom_range(0, 299) == 0, $urandom_range(0, 19) != 0, rq, w, a[0], a[1], d[0], d[1]);
            model_step();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_test_monitor.md
SOC_TEST_MONITOR -- requirements
Module: soc_test_monitor

Interface
REQ-001 Parameter NUM_CH, default 2, number of snooped core data ports (1..8).
REQ-002 Parameter DATA_W, default 32, data and result width.
REQ-003 Parameter ADDR_W, default 32, word-address width of snooped ports.
REQ-004 Parameter FLAG_ADDR, default 0, word address of the per-channel completion flag.
REQ-005 Parameter RESULT_ADDR, default 1, word address of the per-channel result.
REQ-006 Parameter TIMEOUT_CYC, default 100, run cycles before timeout; 32-bit, at least 1.
REQ-007 Port clk_i, in, 1, single clock; all logic on its rising edge.
REQ-008 Port rst_i, in, 1, synchronous active-high reset.
REQ-009 Port start_i, in, 1, level-sampled run request.
REQ-010 Port req_i, in, NUM_CH, per-channel data-port request.
REQ-011 Port we_i, in, NUM_CH, per-channel write enable.
REQ-012 Port addr_i, in, NUM_CH*ADDR_W, per-channel word address, channel c at [c*ADDR_W +: ADDR_W].
REQ-013 Port wdata_i, in, NUM_CH*DATA_W, per-channel write data, same packing.
REQ-014 Port expected_i, in, NUM_CH*DATA_W, per-channel golden result.
REQ-015 Port busy_o, out, 1, high in RUN.
REQ-016 Port done_o, out, 1, high in DONE.
REQ-017 Port timeout_o, out, 1, high in TIMEOUT.
REQ-018 Port pass_o, out, 1, end-of-test verdict.
REQ-019 Port done_mask_o, out, NUM_CH, per-channel flag-seen bits.
REQ-020 Port result_o, out, NUM_CH*DATA_W, captured per-channel results.
REQ-021 Port cycles_o, out, 32, run-cycle counter.

Function
REQ-022 FSM states IDLE, RUN, DONE, TIMEOUT; one-hot or binary, outputs decoded registered.
REQ-023 IDLE->RUN in the cycle after start_i sampled high; entry clears done_mask_o, result_o, cycles_o.
REQ-024 In RUN, cycles_o increments by 1 each cycle, saturating at 2^32-1.
REQ-025 Channel write event: req_i[c] & we_i[c] both high in the same cycle; reads ignored.
REQ-026 Write to RESULT_ADDR in RUN captures wdata into result_o[c] next cycle; later writes overwrite.
REQ-027 Write of nonzero data to FLAG_ADDR in RUN sets done_mask_o[c]; zero writes ignored; bit sticky until next run.
REQ-028 Result writes after done_mask_o[c] is set are ignored (result frozen).
REQ-029 RUN->DONE in the cycle after done_mask_o becomes all ones.
REQ-030 RUN->TIMEOUT when cycles_o reaches TIMEOUT_CYC with done_mask_o not all ones.
REQ-031 Simultaneous final flag set and timeout in the same cycle: DONE wins.
REQ-032 Flag and result writes by one channel in the same cycle cannot occur (distinct addresses); writes from different channels in the same cycle are all captured.
REQ-033 DONE and TIMEOUT hold until start_i sampled low, then return to IDLE; outputs hold their values in IDLE until the next run.
REQ-034 Snooped writes in IDLE, DONE and TIMEOUT are ignored.

Reset
REQ-035 rst_i high at a clock edge forces IDLE and clears all outputs to 0, including mid-RUN; it takes priority over every other event.

Configuration
REQ-036 Macro TEST_MON_CHECK_EN defined: pass_o = done_o AND result_o[c]==expected_i[c] for all c, registered, valid in DONE.
REQ-037 Macro undefined: no comparators, expected_i unused, pass_o = done_o.

Verification
REQ-038 NUM_CH=1: start; ch0 writes 55 to addr 1, then 1 to addr 0 -> done_o rises 1 cycle after flag write, result_o=55, pass_o=1 with expected 55.
REQ-039 NUM_CH=2: ch0 flags at cycle 10, ch1 at cycle 30 -> done_mask_o=01 then 11, done_o 1 cycle after cycle 30.
REQ-040 TIMEOUT_CYC=100, no flag writes -> timeout_o rises when cycles_o reaches 100, done_o=0, pass_o=0.
REQ-041 Last flag written in the cycle cycles_o reaches TIMEOUT_CYC -> done_o=1, timeout_o=0.
REQ-042 rst_i pulsed mid-RUN after result write of 8 -> next cycle all outputs 0, state IDLE; result write of 8 afterwards with start_i low -> result_o stays 0.
REQ-043 With TEST_MON_CHECK_EN: result 21, expected 34 -> done_o=1, pass_o=0; without the macro -> pass_o=1.
